// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-command APB requester with one-hot register select
// and a wait-state timeout that aborts transfers the slave never acknowledges.
module apb_master_bridge #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          preset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  output logic [7:0]    select_reg,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic [DW-1:0] rsp_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t        state_q, state_d;
  logic          psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          expire;
  assign expire = (state_q == ACCESS) && !pready && (cnt_q == CW'(TIMEOUT - 1));
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      cnt_q         <= cnt_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE)   ? (cmd_valid ? SETUP : IDLE) :
              (state_q == SETUP)  ? ACCESS :
              (state_q == ACCESS) ? ((pready || expire) ? RESP : ACCESS) :
                                    IDLE;
  end
  always_comb begin
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_rdata_d   = '0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        psel_d   = 1'b1;
        pwrite_d = cmd_write;
        paddr_d  = cmd_addr;
        pwdata_d = cmd_wdata;
        cnt_d    = '0;
      end
      SETUP: penable_d = 1'b1;
      ACCESS: if (pready) begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = pslverr;
        rsp_rdata_d = pwrite_q ? '0 : prdata;
      end else begin
        cnt_d = cnt_q + CW'(1);
        // slave never answered: release the bus and report the abort
        if (expire) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
  end
  assign cmd_ready   = (state_q == IDLE);
  assign select_reg  = (psel_q && ((paddr_q >> 3) == '0)) ? (8'd1 << paddr_q[2:0]) : 8'd0;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed vectors for the APB bridge with hand-computed responses.
module tb_apb_master_bridge;
  logic       pclk = 1'b0;
  logic       preset_n, cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, select_reg, prdata;
  logic       pready, pslverr, rsp_valid, rsp_err, rsp_timeout;
  logic [7:0] rsp_rdata;
  int checks = 0;
  int errors = 0;
  always #5 pclk = ~pclk;
  apb_master_bridge #(.AW(8), .DW(8), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset_n(preset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .select_reg(select_reg), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .rsp_rdata(rsp_rdata)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Caller sits at a negedge in IDLE; waits = ACCESS cycles with pready=0 before it rises,
  // n = ACCESS cycles the bridge is expected to spend.
  task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d, input int waits,
                      input logic err, input logic [7:0] rd, input int n, input logic [7:0] sel,
                      input logic e_err, input logic e_to, input logic [7:0] e_rd);
    chk("idle_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    pready = 1'b1; pslverr = 1'b1; prdata = 8'hEE;
    @(negedge pclk);
    cmd_valid = 1'b0;
    chk("setup", {cmd_ready, psel, penable, select_reg, rsp_valid}, {1'b0, 1'b1, 1'b0, sel, 1'b0});
    @(negedge pclk);
    for (int i = 0; i < n; i++) begin
      chk("access", {psel, penable, pwrite, paddr, pwdata, select_reg, rsp_valid},
          {1'b1, 1'b1, w, a, d, sel, 1'b0});
      pready  = (i >= waits);
      pslverr = (i >= waits) && err;
      prdata  = (i >= waits) ? rd : 8'hEE;
      @(negedge pclk);
    end
    chk("resp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata, psel, penable, cmd_ready},
        {1'b1, e_err, e_to, e_rd, 3'b000});
    pready = 1'b1; pslverr = 1'b1;
    @(negedge pclk);
    chk("resp_clear", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata, psel, cmd_ready},
        {11'h000, 1'b0, 1'b1});
  endtask
  initial begin
    preset_n = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h05; cmd_wdata = 8'hA5;
    pready = 1'b1; pslverr = 1'b0; prdata = 8'h00;
    repeat (3) @(negedge pclk);
    chk("reset_out", {psel, penable, pwrite, paddr, pwdata, select_reg, rsp_valid, rsp_err,
        rsp_timeout, rsp_rdata}, 64'h0);
    chk("reset_ready", cmd_ready, 1'b1);
    preset_n = 1'b1;
    xfer(1'b1, 8'h05, 8'hA5, 0,  1'b0, 8'h00, 1,  8'h20, 1'b0, 1'b0, 8'h00);
    xfer(1'b0, 8'h02, 8'h11, 3,  1'b0, 8'h3C, 4,  8'h04, 1'b0, 1'b0, 8'h3C);
    xfer(1'b1, 8'h1F, 8'h5A, 99, 1'b0, 8'h00, 16, 8'h00, 1'b1, 1'b1, 8'h00);
    xfer(1'b0, 8'h03, 8'h00, 0,  1'b1, 8'h77, 1,  8'h08, 1'b1, 1'b0, 8'h77);
    xfer(1'b0, 8'h07, 8'h00, 15, 1'b0, 8'h5A, 16, 8'h80, 1'b0, 1'b0, 8'h5A);
    xfer(1'b1, 8'h00, 8'hC3, 0,  1'b1, 8'hFF, 1,  8'h01, 1'b1, 1'b0, 8'h00);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h04;
    @(negedge pclk);
    cmd_valid = 1'b0; pready = 1'b0;
    repeat (2) @(negedge pclk);
    chk("pre_reset_access", {psel, penable, select_reg}, {2'b11, 8'h10});
    #2 preset_n = 1'b0;
    #1 chk("async_reset", {psel, penable, select_reg, rsp_valid}, 11'h000);
    pready = 1'b1;
    @(negedge pclk);
    chk("reset_no_rsp", {rsp_valid, psel, cmd_ready}, 3'b001);
    preset_n = 1'b1;
    xfer(1'b0, 8'h06, 8'h00, 1,  1'b0, 8'h9E, 2,  8'h40, 1'b0, 1'b0, 8'h9E);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
